// File: rtl/timer_pkg.sv
// Shared types and default sizes for the synchronous down-timer.
package timer_pkg;

  localparam int unsigned DEF_WIDTH      = 4;
  localparam int unsigned DEF_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the down-timer: emits a tick every prescale_i+1 cycles while run_i is high.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  run_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // A larger count than a freshly lowered prescale simply wraps through the maximum.
  assign tick_o = run_i && (cnt_q == prescale_i);

  // Next divider value: clear wins, wrap on tick, otherwise advance only while running.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sync_down_timer.sv
// Loadable synchronous down-timer with one-shot / auto-reload modes and a prescaled tick.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | not counting; count held
//   RUN     | decrementing on every prescaler tick
//   EXPIRED | one-shot reached terminal count; done high until cleared
module sync_down_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc,
  output logic                  done
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tick;
  logic             tick_take;
  logic             presc_clear;

  // Divider restarts on every load and whenever RUN is entered, so the first tick is a full period away.
  assign presc_clear = load || ((state_d == RUN) && (state_q != RUN));

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (presc_clear),
    .run_i      (state_q == RUN),
    .prescale_i (prescale),
    .tick_o     (tick)
  );

  // A tick only acts when nothing of higher priority claims the cycle.
  assign tick_take = tick && !reset && !load && !stop;

  // Next state / count: load > stop > start > tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      if (stop) begin
        state_d = IDLE;
      end else if (start) begin
        state_d = RUN;
      end else if (state_q == EXPIRED) begin
        state_d = IDLE;
      end
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = IDLE;
      end
    end else if (start && (state_q != RUN)) begin
      if (state_q == EXPIRED) begin
        count_d = reload_q;
      end
      state_d = RUN;
    end else if (tick_take) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else if (auto_reload) begin
        count_d = reload_q;
      end else begin
        state_d = EXPIRED;
      end
    end
  end

  // State, count and reload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == EXPIRED);
  assign tc    = tick_take && (count_q == '0);

endmodule

// File: tb/tb_sync_down_timer.sv
// Scoreboard bench for sync_down_timer: directed scenarios followed by random traffic.
module tb_sync_down_timer;

  logic       clk = 1'b0;
  logic       reset, load, start, stop, auto_reload;
  logic [3:0] load_value, prescale;
  logic [3:0] count;
  logic       busy, tc, done;

  always #5 clk = ~clk;

  sync_down_timer #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .count       (count),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  typedef struct packed {
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       tc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: timer "mode", remaining count, reload value, clocks since last tick.
  typedef enum int {M_IDLE, M_RUN, M_EXP} mmode_t;
  mmode_t m_mode   = M_IDLE;
  int     m_count  = 0;
  int     m_reload = 0;
  int     m_phase  = 0;
  int     ps_cur   = 0;
  bit     ar_cur   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL cyc=%0d %s got=%0d expected=%0d", cyc, nm, got, exp);
  endtask

  // Drive one cycle of inputs, record what the timer must show this cycle, advance the model.
  task automatic step(input bit rst, input bit ld, input int lv, input bit st, input bit sp,
                      input bit ar, input int ps);
    exp_t e;
    bit   tk;
    @(posedge clk);
    #1;
    reset = rst; load = ld; load_value = lv[3:0]; start = st; stop = sp;
    auto_reload = ar; prescale = ps[3:0];
    tk = (m_mode == M_RUN) && !rst && !ld && !sp && (m_phase == ps);
    e.count = m_count[3:0];
    e.busy  = (m_mode == M_RUN);
    e.done  = (m_mode == M_EXP);
    e.tc    = tk && (m_count == 0);
    sb_q.push_back(e);
    cyc++;
    if (rst) begin
      m_mode = M_IDLE; m_count = 0; m_reload = 0; m_phase = 0;
    end else if (ld) begin
      m_count = lv; m_reload = lv; m_phase = 0;
      if (sp) m_mode = M_IDLE;
      else if (st) m_mode = M_RUN;
      else if (m_mode == M_EXP) m_mode = M_IDLE;
    end else if (sp) begin
      if (m_mode == M_RUN) m_mode = M_IDLE;
    end else if (st && m_mode != M_RUN) begin
      if (m_mode == M_EXP) m_count = m_reload;
      m_mode  = M_RUN;
      m_phase = 0;
    end else if (m_mode == M_RUN) begin
      if (tk) begin
        m_phase = 0;
        if (m_count != 0) m_count = m_count - 1;
        else if (ar) m_count = m_reload;
        else m_mode = M_EXP;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, ar_cur, ps_cur);
  endtask

  task automatic do_load(input int lv, input bit with_start);
    step(0, 1, lv, with_start, 0, ar_cur, ps_cur);
  endtask

  task automatic do_start();
    step(0, 0, 0, 1, 0, ar_cur, ps_cur);
  endtask

  // Monitor: every cycle the timer presents outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("count", count, e.count);
        chk("busy",  busy,  e.busy);
        chk("done",  done,  e.done);
        chk("tc",    tc,    e.tc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rr, rl, rs, rp;
    reset = 1'b1; load = 1'b0; load_value = '0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; prescale = '0;
    @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0);

    // reset in the middle of a run
    ps_cur = 0; ar_cur = 0;
    do_load(9, 0); do_start(); idle_n(3);
    step(1, 0, 0, 0, 0, ar_cur, ps_cur);
    idle_n(2);

    // one-shot from 3
    do_load(3, 0); do_start(); idle_n(7);

    // auto-reload from 2
    ar_cur = 1;
    do_load(2, 0); do_start(); idle_n(8);
    step(0, 0, 0, 0, 1, ar_cur, ps_cur);

    // prescaled one-shot
    ar_cur = 0; ps_cur = 2;
    do_load(1, 0); do_start(); idle_n(9);

    // priority: stop+start in RUN, then load+start from EXPIRED
    ps_cur = 0;
    do_load(5, 0); do_start(); idle_n(2);
    step(0, 0, 0, 1, 1, ar_cur, ps_cur);
    idle_n(2);
    do_start(); idle_n(5);
    do_load(7, 1); idle_n(3);
    step(0, 0, 0, 1, 0, ar_cur, ps_cur);
    idle_n(6);
    do_start(); idle_n(2);
    step(0, 1, 4, 0, 1, ar_cur, ps_cur);
    idle_n(2);

    // boundaries: zero reload auto-reload, full-scale one-shot
    ar_cur = 1;
    do_load(0, 0); do_start(); idle_n(5);
    step(0, 0, 0, 0, 1, ar_cur, ps_cur);
    ar_cur = 0;
    do_load(15, 0); do_start(); idle_n(19);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      rl = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) ar_cur = ~ar_cur;
      if (m_mode != M_RUN || rl) ps_cur = int'($urandom_range(0, 3));
      step(rr, rl, int'($urandom_range(0, 15)), rs, rp, ar_cur, ps_cur);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
